ksa_sub_pipe: RTL and testbench
===============================

// Module: ksa_sub_pipe
// PURPOSE
//  Pipelined Kogge-Stone subtractor: diff = a - b, computed as a + ~b + 1 on a KS parallel-prefix tree.
//  Counterpart to the KSA adder family; feeds datapaths that need the inverse operation at full throughput.
//  One pipeline register per prefix level; valid/ready handshake on both sides; one result per cycle when unstalled.
// PARAMETERS
//  WIDTH  8  operand width; power of two, >= 2
//  LVLS   $clog2(WIDTH)  prefix levels (localparam, not overridable)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      a/b presented
//  in_ready   out  1      block accepts a/b this cycle
//  a          in   WIDTH  minuend, unsigned/two's complement
//  b          in   WIDTH  subtrahend
//  out_valid  out  1      diff/borrow valid
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b mod 2^WIDTH
//  borrow     out  1      1 iff a < b unsigned (= ~carry_out)
//  ovf        out  1      signed overflow; present only with KSA_SUB_OVF_EN
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage valid bits, out_valid, diff, borrow, ovf -> 0; pipeline data regs -> 0.
//  - Stage 0 (on accept): g=a&~b, p=a^~b; carry-in 1 folded into bit 0: g0=a0|~b0; store p for sum.
//  - Stages 1..LVLS: level k combines span 2^(k-1): G=Gi|(Pi&Gprev), P=Pi&Pprev; bits below span pass through.
//  - Output stage: diff[0]=~p[0] (p^cin), diff[i]=p[i]^G[i-1]; borrow=~G[WIDTH-1].
//  - Latency: LVLS+2 cycles from accept (in_valid&in_ready) to out_valid; WIDTH=8 -> 5 cycles.
//  - Handshake: transfer on valid&ready; out_valid/diff/borrow hold stable while out_valid&~out_ready.
//  - Stall: global; stall = out_valid & ~out_ready; all stages hold; in_ready = ~stall (combinational).
//  - Bubbles propagate as invalid stages; no bubble collapsing. Throughput 1/cycle with out_ready=1.
//  - in_valid=0 with in_ready=1: stage 0 loads valid=0; data regs may hold don't-care.
//  - Simultaneous drain and accept in a stall-release cycle: both occur; no loss, no duplicate.
//  - Reset mid-operation: in-flight results dropped; out_valid low the cycle after reset asserts.
//  - Order preserved; no reordering; results never dropped except by reset.
// CONFIGURATION
//  KSA_SUB_OVF_EN defined: ovf port exists; ovf=(a[W-1]^b[W-1])&(diff[W-1]^a[W-1]); sign bits
//   carried down the pipeline; ovf registered with diff, same latency/hold rules, reset 0.
//  Not defined: ovf port and sign-bit pipeline regs absent; all other behaviour identical.
// STRUCTURE
//  Shared package ksa_pkg: prefix-level count function, span constant per level, g/p pair struct typedef.
//  Sub-module ksa_prefix_cell (combinational G/P black cell), instantiated per bit per level via generate.
//  Top holds stage valid bits, stall logic and all registers; no FSM beyond per-stage valid shift chain.
// TESTING
//  1 a=8'h05,b=8'h03 -> diff=8'h02,borrow=0,ovf=0, out_valid exactly 5 cycles after accept.
//  2 a=8'h03,b=8'h05 -> diff=8'hFE,borrow=1; a=8'h80,b=8'h01 -> diff=8'h7F,borrow=0,ovf=1.
//  3 256 back-to-back random pairs, out_ready=1 -> one result/cycle, in order, match a-b model.
//  4 out_ready=0 for 10 cycles with 5 in flight -> in_ready=0, diff held stable, then 5 results in order.
//  5 rst_n pulsed low with 3 results in flight -> out_valid=0 immediately, none emerge afterward.
//  6 Exhaustive 65536 pairs with random out_ready/in_valid gaps -> all match model incl. borrow/ovf.

Source files
------------

// File: rtl/ksa_pkg.sv
// ---------------------------------------------------------------------------
// ksa_pkg
// Shared definitions for the Kogge-Stone adder/subtractor family.
//   gp_t        : generate/propagate pair carried through the prefix tree
//   ksa_levels  : number of prefix levels for a given operand width
//   ksa_span    : bit distance combined by a given prefix level (1-based)
// ---------------------------------------------------------------------------
package ksa_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int ksa_levels(input int width);
    return $clog2(width);
  endfunction

  // Level k combines each bit with the bit 2^(k-1) positions below it.
  function automatic int ksa_span(input int level);
    return 1 << (level - 1);
  endfunction

endpackage

// File: rtl/ksa_prefix_cell.sv
// ---------------------------------------------------------------------------
// ksa_prefix_cell
// Combinational Kogge-Stone black cell: merges a higher group (hi) with the
// adjacent lower group (lo).
//   i_g_hi, i_p_hi : generate/propagate of the higher group
//   i_g_lo, i_p_lo : generate/propagate of the lower group
//   o_g, o_p       : combined group generate/propagate
// ---------------------------------------------------------------------------
module ksa_prefix_cell
  import ksa_pkg::*;
(
  input  logic i_g_hi,
  input  logic i_p_hi,
  input  logic i_g_lo,
  input  logic i_p_lo,
  output logic o_g,
  output logic o_p
);

  gp_t w_res;

  assign w_res.g = i_g_hi | (i_p_hi & i_g_lo);
  assign w_res.p = i_p_hi & i_p_lo;

  assign o_g = w_res.g;
  assign o_p = w_res.p;

endmodule

// File: rtl/ksa_sub_pipe.sv
// ---------------------------------------------------------------------------
// ksa_sub_pipe
// Pipelined Kogge-Stone subtractor: diff = a - b, evaluated as a + ~b + 1.
// One register stage for g/p generation, one per prefix level, one for the
// output; latency LVLS+2 cycles from accept to out_valid. Full throughput
// when out_ready stays high; a global stall freezes every stage.
//
// Ports
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : input handshake for a, b
//   a, b                 : minuend, subtrahend (WIDTH bits)
//   out_valid / out_ready: output handshake for diff, borrow (and ovf)
//   diff                 : a - b mod 2^WIDTH
//   borrow               : 1 when a < b (unsigned)
//   ovf                  : signed overflow, only when KSA_SUB_OVF_EN is defined
//
// Build option: `define KSA_SUB_OVF_EN to add the ovf port and the sign-bit
// pipeline that feeds it.
// ---------------------------------------------------------------------------
module ksa_sub_pipe
  import ksa_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef KSA_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int LVLS = ksa_levels(WIDTH);

  // Stage 0 combinational g/p and the per-level prefix results
  gp_t  [WIDTH-1:0] w_gp0;
  logic [WIDTH-1:0] w_p0;
  gp_t  [WIDTH-1:0] w_gp [1:LVLS];

  // Pipeline registers: index 0 is the g/p stage, LVLS is the last prefix level
  gp_t  [WIDTH-1:0] r_gp   [0:LVLS];
  logic [WIDTH-1:0] r_psum [0:LVLS];
  logic [LVLS:0]    r_vld;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_stall;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_unused_p;

  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // Stage 0: operate on ~b; the +1 carry-in is folded into bit 0 generate
  assign w_p0 = a ^ ~b;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage0
    if (gi == 0) begin : g_cin
      assign w_gp0[gi].g = a[gi] | ~b[gi];
    end else begin : g_plain
      assign w_gp0[gi].g = a[gi] & ~b[gi];
    end
    assign w_gp0[gi].p = w_p0[gi];
  end

  // Prefix levels: bits below the span already hold their final group value
  for (genvar gl = 1; gl <= LVLS; gl++) begin : g_level
    localparam int SPAN = ksa_span(gl);
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi >= SPAN) begin : g_cell
        ksa_prefix_cell u_cell (
          .i_g_hi (r_gp[gl-1][gi].g),
          .i_p_hi (r_gp[gl-1][gi].p),
          .i_g_lo (r_gp[gl-1][gi-SPAN].g),
          .i_p_lo (r_gp[gl-1][gi-SPAN].p),
          .o_g    (w_gp[gl][gi].g),
          .o_p    (w_gp[gl][gi].p)
        );
      end else begin : g_pass
        assign w_gp[gl][gi] = r_gp[gl-1][gi];
      end
    end
  end

  // Sum: bit 0 sees the carry-in of 1, higher bits the group carry below them
  assign w_diff[0] = ~r_psum[LVLS][0];
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_sum
    assign w_diff[gi] = r_psum[LVLS][gi] ^ r_gp[LVLS][gi-1].g;
  end
  assign w_borrow = ~r_gp[LVLS][WIDTH-1].g;

  // Group propagate of the final level has no consumer
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_unused
    assign w_unused_p[gi] = r_gp[LVLS][gi].p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld       <= '0;
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      for (int l = 0; l <= LVLS; l++) begin
        r_gp[l]   <= '0;
        r_psum[l] <= '0;
      end
    end else if (!w_stall) begin
      r_vld[0]  <= in_valid;
      r_gp[0]   <= w_gp0;
      r_psum[0] <= w_p0;
      for (int l = 1; l <= LVLS; l++) begin
        r_vld[l]  <= r_vld[l-1];
        r_gp[l]   <= w_gp[l];
        r_psum[l] <= r_psum[l-1];
      end
      r_out_valid <= r_vld[LVLS];
      r_diff      <= w_diff;
      r_borrow    <= w_borrow;
    end
  end

  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;

`ifdef KSA_SUB_OVF_EN
  // Operand sign bits travel alongside the prefix data
  logic [LVLS:0] r_sa;
  logic [LVLS:0] r_sb;
  logic          r_ovf;
  logic          w_ovf;

  assign w_ovf = (r_sa[LVLS] ^ r_sb[LVLS]) & (w_diff[WIDTH-1] ^ r_sa[LVLS]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_ovf <= 1'b0;
    end else if (!w_stall) begin
      r_sa  <= {r_sa[LVLS-1:0], a[WIDTH-1]};
      r_sb  <= {r_sb[LVLS-1:0], b[WIDTH-1]};
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// ---------------------------------------------------------------------------
// tb_ksa_sub_pipe
// Self-checking bench for ksa_sub_pipe (WIDTH=8). Expected results come from
// plain integer arithmetic on a, b. Define KSA_SUB_OVF_EN for both the bench
// and the design to include the ovf output in every result comparison.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ksa_sub_pipe;

  localparam int LAT = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] diff;
  logic       borrow;
  logic [9:0] got;

`ifdef KSA_SUB_OVF_EN
  logic ovf;
  localparam logic [9:0] MASK = 10'h3FF;
  assign got = {ovf, borrow, diff};
`else
  localparam logic [9:0] MASK = 10'h1FF;
  assign got = {1'b0, borrow, diff};
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ksa_sub_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef KSA_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: {ovf, borrow, diff} from integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
    int ux, uy, sx, sy, sd;
    logic [7:0] d;
    logic bo, ov;
    ux = int'(x);
    uy = int'(y);
    d  = 8'((ux - uy + 256) % 256);
    bo = (ux < uy);
    sx = (ux > 127) ? ux - 256 : ux;
    sy = (uy > 127) ? uy - 256 : uy;
    sd = sx - sy;
    ov = (sd > 127) || (sd < -128);
    return {ov, bo, d};
  endfunction

  // Drives one operand pair into an empty pipe and waits for its result.
  task automatic send_one(input logic [7:0] x, input logic [7:0] y,
                          output int lat, output logic [9:0] res);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = got;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if ((got & MASK) !== 10'h000) begin
      n_fail++; $display("FAIL reset_result: got %h expected 000", got & MASK);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_directed();
    logic [7:0] ta [5];
    logic [7:0] tb [5];
    logic [9:0] te [5];
    int lat;
    logic [9:0] res;
    ta[0] = 8'h05; tb[0] = 8'h03; te[0] = {1'b0, 1'b0, 8'h02};
    ta[1] = 8'h03; tb[1] = 8'h05; te[1] = {1'b0, 1'b1, 8'hFE};
    ta[2] = 8'h80; tb[2] = 8'h01; te[2] = {1'b1, 1'b0, 8'h7F};
    ta[3] = 8'h00; tb[3] = 8'h00; te[3] = {1'b0, 1'b0, 8'h00};
    ta[4] = 8'h7F; tb[4] = 8'hFF; te[4] = {1'b1, 1'b1, 8'h80};
    for (int i = 0; i < 5; i++) begin
      send_one(ta[i], tb[i], lat, res);
      n_checks++;
      if (lat != LAT) begin
        n_fail++; $display("FAIL latency a=%h b=%h: got %0d cycles expected %0d", ta[i], tb[i], lat, LAT);
      end
      n_checks++;
      if ((res & MASK) !== (te[i] & MASK)) begin
        n_fail++; $display("FAIL directed a=%h b=%h: got %h expected %h", ta[i], tb[i], res & MASK, te[i] & MASK);
      end
      $display("directed a=%h b=%h -> {ovf,borrow,diff}=%h latency=%0d", ta[i], tb[i], res & MASK, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] q [$];
    logic [15:0] e;
    logic [9:0]  exp_v;
    int sent = 0, recv = 0, cyc = 0;
    bit started = 0;
    out_ready = 1'b1;
    while (recv < 256 && cyc < 1000) begin
      @(negedge clk);
      if (sent < 256) begin
        in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready);
        end else begin
          q.push_back({a, b}); sent++;
        end
      end
      if (started) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_gap: out_valid got %b expected 1 at result %0d", out_valid, recv);
        end
      end
      if (out_valid === 1'b1) begin
        started = 1;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: got result %h expected none", got & MASK);
        end else begin
          e = q.pop_front();
          exp_v = model(e[15:8], e[7:0]);
          if ((got & MASK) !== (exp_v & MASK)) begin
            n_fail++; $display("FAIL b2b_result a=%h b=%h: got %h expected %h", e[15:8], e[7:0], got & MASK, exp_v & MASK);
          end
        end
        recv++;
      end
      cyc++;
    end
    n_checks++;
    if (recv != 256) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d results expected 256", recv);
    end
    in_valid = 1'b0;
    $display("test_back_to_back: %0d results in %0d cycles", recv, cyc);
  endtask

  task automatic test_stall();
    logic [15:0] q [$];
    logic [15:0] e;
    logic [9:0]  exp_v;
    int cyc = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stall_fill_in_ready: got %b expected 1", in_ready);
      end else begin
        q.push_back({a, b});
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    e = q[0];
    exp_v = model(e[15:8], e[7:0]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_flags: got out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
      end
      n_checks++;
      if ((got & MASK) !== (exp_v & MASK)) begin
        n_fail++; $display("FAIL stall_hold: got %h expected %h", got & MASK, exp_v & MASK);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    while (q.size() > 0 && cyc < 30) begin
      #1;
      if (out_valid === 1'b1) begin
        e = q.pop_front();
        exp_v = model(e[15:8], e[7:0]);
        n_checks++;
        if ((got & MASK) !== (exp_v & MASK)) begin
          n_fail++; $display("FAIL stall_drain a=%h b=%h: got %h expected %h", e[15:8], e[7:0], got & MASK, exp_v & MASK);
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL stall_timeout: got %0d results left expected 0", q.size());
    end
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_extra: out_valid got %b expected 0", out_valid);
    end
    $display("test_stall: drained after %0d cycles", cyc);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
    end
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: out_valid got %b expected 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_async: out_valid got %b expected 0", out_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL midreset_leak: out_valid got %b expected 0 at cycle %0d", out_valid, i);
      end
    end
    $display("test_reset_midflight done");
  endtask

  task automatic test_exhaustive();
    logic [15:0] q [$];
    logic [15:0] e;
    logic [9:0]  exp_v;
    int k = 0, recv = 0, cyc = 0;
    bit acc = 0;
    while (recv < 65536 && cyc < 85000) begin
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      out_ready = (($urandom % 32) != 0);
      if (!in_valid && k < 65536 && (($urandom % 32) != 0)) begin
        in_valid = 1'b1; a = 8'(k >> 8); b = 8'(k);
      end
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back({a, b}); k++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL exh_extra: got result %h expected none", got & MASK);
        end else begin
          e = q.pop_front();
          exp_v = model(e[15:8], e[7:0]);
          if ((got & MASK) !== (exp_v & MASK)) begin
            n_fail++; $display("FAIL exh_result a=%h b=%h: got %h expected %h", e[15:8], e[7:0], got & MASK, exp_v & MASK);
          end
        end
        recv++;
      end
      cyc++;
    end
    n_checks++;
    if (recv != 65536) begin
      n_fail++; $display("FAIL exh_timeout: got %0d results expected 65536", recv);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    $display("test_exhaustive: %0d results in %0d cycles", recv, cyc);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
